uart_pio_bridge: RTL and testbench
==================================

Name: uart_pio_bridge

Overview:
- UART-controlled parallel I/O block: the LED, switch and button PIOs are driven and read over a serial link instead of through a soft processor.
- Contains an 8N1 receiver, an 8N1 transmitter, a two-state command parser, and debounced button event reporting.
- LED, switch and button widths and the baud divisor are parametrised.
- Sits at board top level beside the PLL and consumes the PLL lock output.

Parameters:
BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 8 to 65535.
LED_W, 8, LED output width; legal range 1 to 8.
SW_W, 3, switch input width.
BTN_W, 2, button input width; SW_W + BTN_W <= 8.
DEBOUNCE_CYC, 500000, consecutive stable cycles required before a button level is accepted.

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
pll_locked  in  1  while low, the whole block is held in its reset state
uart_rxd  in  1  serial input, asynchronous, idles high
uart_txd  out  1  serial output, idles high
pio_led_export  out  LED_W  LED drive
pio_switch_export  in  SW_W  switches, asynchronous
pio_button_export  in  BTN_W  buttons, asynchronous, active-low
frame_err_cnt  out  8  saturating error counter

Behaviour:
- Reset condition: reset_reset=1 or pll_locked=0 at a clock edge. Resulting state:
  - uart_txd=1, pio_led_export=0, frame_err_cnt=0.
  - RX, TX and parser return to their idle states.
  - Reply slot and all event flags are cleared.
  - Debounced button levels are set to 1 (released).
- Synchronisers: uart_rxd, switches and buttons each pass through 2 flip-flops before use.
- RX:
  - States: IDLE, START, DATA, STOP.
  - IDLE: a synced 0 starts a half-bit wait (BAUD_DIV/2 cycles). If the line has returned to 1 at that point, go back to IDLE (glitch rejected).
  - DATA: 8 bits, LSB first, each sampled BAUD_DIV cycles after the previous sample.
  - STOP: stop bit sampled. If 1, the byte is valid and rx_valid pulses for 1 cycle. If 0, framing error: byte discarded, frame_err_cnt increments (saturates at 255), then wait for the line to return to 1 before entering IDLE.
- TX:
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV cycles.
  - A new frame may start on the cycle after the stop bit ends.
- Parser:
  - States: CMD, ARG.
  - In CMD:
    - 0x4C 'L': go to ARG.
    - 0x52 'R': reply {btn_deb_n inverted (1 = pressed), switches}, packed LSB-first, zero-extended to 8 bits.
    - Any other byte: reply 0x15 (NAK).
  - In ARG: the next valid byte sets pio_led_export <= byte[LED_W-1:0], reply 0x06 (ACK), go to CMD.
  - A framing error while in ARG returns the parser to CMD with LEDs unchanged.
- Reply slot:
  - Single-entry slot.
  - If a reply is generated while the slot is still occupied, the new reply is dropped and frame_err_cnt increments.
- Buttons:
  - A debounced level changes only after DEBOUNCE_CYC consecutive cycles with a synced value differing from the current level.
  - A debounced 1->0 transition on button i sets event flag i. A flag already set stays set; it is not counted twice.
- TX arbitration, when TX is idle:
  - The reply slot has priority.
  - Otherwise the lowest-index set event flag is sent as byte 0x80|i.
  - The slot or flag clears on the cycle the start bit begins.
- Latency: the reply's start bit appears on uart_txd no later than 3 cycles after the stop-bit sample of the command byte, when TX is idle.
- Simultaneous events:
  - A reply load and a TX grab in the same cycle are both honoured: the slot ends up occupied with the new reply.
  - A flag set and a flag clear for the same button in the same cycle leave the flag set.

Test Plan:
- Setup: BAUD_DIV=16, DEBOUNCE_CYC=8.
- Reset: after reset, uart_txd=1, LEDs=0x00, frame_err_cnt=0. With pll_locked=0 and a full RX frame applied, uart_txd stays 1 throughout.
- LED write: send 0x4C then 0xA5 -> pio_led_export=0xA5 after the second stop sample; TX emits 0x06 with its start bit within 3 cycles.
- Status read: switches=3'b101, button0 held low for more than 8 cycles, send 0x52 -> TX emits 0x0D.
- Errors:
  - Send 0x33 -> TX emits 0x15.
  - Frame with stop bit=0 -> no reply; frame_err_cnt=1.
  - 0x4C followed by a frame with bad stop bit -> LEDs unchanged; the next byte 0x52 is parsed as a command.
- Button events:
  - Press buttons 1 and 0 in the same cycle -> TX emits 0x80, then 0x81 back-to-back.
  - A 5-cycle bounce on a button produces no event.
- Priority and saturation:
  - An event pending while 0x52 arrives -> the reply is sent first.
  - 300 framing errors -> frame_err_cnt=255.

Source files
------------

// File: rtl/uart_pio_bridge.sv
// uart_pio_bridge: serial-controlled LED/switch/button PIO.
// The block contains an 8N1 receiver, an 8N1 transmitter, a two-state command
// parser, a single-entry reply slot, and per-button debounce with press events.
//
// Handshakes inside the block:
//   rx_valid / rx_err are one-cycle strobes. They have no ready, and the parser
//   consumes them on the cycle they are high.
//   Reply slot and event flags act as "valid" toward the transmitter. The
//   transmitter "readies" them with tx_free. A transfer happens on the cycle
//   both are high, and that same cycle drives the start bit.
module uart_pio_bridge #(
  parameter int BAUD_DIV     = 434,
  parameter int LED_W        = 8,
  parameter int SW_W         = 3,
  parameter int BTN_W        = 2,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              pll_locked,
  input  logic              uart_rxd,
  output logic              uart_txd,
  output logic [LED_W-1:0]  pio_led_export,
  input  logic [SW_W-1:0]   pio_switch_export,
  input  logic [BTN_W-1:0]  pio_button_export,
  output logic [7:0]        frame_err_cnt
);

  localparam int             CW        = 16;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam int             DW        = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

  // Losing PLL lock holds the whole block in reset, the same as reset_reset.
  logic rst;
  assign rst = reset_reset | ~pll_locked;

  // ---------------- synchronisers ----------------
  logic [1:0]       rxd_sync;
  logic [SW_W-1:0]  sw_m, sw_s;
  logic [BTN_W-1:0] btn_m, btn_s;
  logic             rx_s;
  assign rx_s = rxd_sync[1];

  // Two-flop synchronisers for all asynchronous inputs.
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      rxd_sync <= 2'b11;
      sw_m     <= '0;
      sw_s     <= '0;
      btn_m    <= '1;
      btn_s    <= '1;
    end else begin
      rxd_sync <= {rxd_sync[0], uart_rxd};
      sw_m     <= pio_switch_export;
      sw_s     <= sw_m;
      btn_m    <= pio_button_export;
      btn_s    <= btn_m;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t       rx_state, rx_state_nx;
  logic [CW-1:0]   rx_cnt, rx_cnt_nx;
  logic [2:0]      rx_bit, rx_bit_nx;
  logic [7:0]      rx_sh, rx_sh_nx;
  logic            rx_hold, rx_hold_nx;   // after a framing error: wait for idle line
  logic            rx_valid, rx_err;

  // Receiver next state: half-bit start check, 8 data samples, then a stop check.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    rx_hold_nx  = rx_hold;
    rx_valid    = 1'b0;
    rx_err      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) rx_cnt_nx = rx_cnt - CW'(1);
        else if (rx_s) rx_state_nx = RX_IDLE;          // glitch rejected
        else begin
          rx_state_nx = RX_DATA;
          rx_cnt_nx   = BIT_LAST;
          rx_bit_nx   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) rx_cnt_nx = rx_cnt - CW'(1);
        else begin
          rx_sh_nx  = {rx_s, rx_sh[7:1]};
          rx_cnt_nx = BIT_LAST;
          rx_bit_nx = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_hold) begin
          if (rx_s) begin
            rx_hold_nx  = 1'b0;
            rx_state_nx = RX_IDLE;
          end
        end else if (rx_cnt != '0) rx_cnt_nx = rx_cnt - CW'(1);
        else if (rx_s) begin
          rx_valid    = 1'b1;
          rx_state_nx = RX_IDLE;
        end else begin
          rx_err     = 1'b1;
          rx_hold_nx = 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_hold  <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_sh    <= rx_sh_nx;
      rx_hold  <= rx_hold_nx;
    end
  end

  // ---------------- button debounce ----------------
  logic [BTN_W-1:0] btn_deb, btn_fall;
  logic [DW-1:0]    deb_cnt [BTN_W];

  // A level is accepted after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < BTN_W; i++) begin
      if (rst) begin
        deb_cnt[i] <= '0;
        btn_deb[i] <= 1'b1;
      end else if (btn_s[i] == btn_deb[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == DEB_LAST) begin
        deb_cnt[i] <= '0;
        btn_deb[i] <= btn_s[i];
      end else begin
        deb_cnt[i] <= deb_cnt[i] + DW'(1);
      end
    end
  end

  // A press is the debounced 1->0 transition about to be accepted this cycle.
  always_comb begin
    btn_fall = '0;
    for (int i = 0; i < BTN_W; i++)
      btn_fall[i] = btn_deb[i] && !btn_s[i] && (deb_cnt[i] == DEB_LAST);
  end

  // ---------------- parser ----------------
  typedef enum logic {P_CMD, P_ARG} p_state_t;
  p_state_t         p_state, p_state_nx;
  logic [LED_W-1:0] led_nx;
  logic             rep_load;
  logic [7:0]       rep_byte, status_byte;

  // Status byte: switches in the low bits, pressed buttons above, zero-extended.
  always_comb begin
    status_byte = '0;
    status_byte[SW_W+BTN_W-1:0] = {~btn_deb, sw_s};
  end

  // Parser next state. 'L' takes one argument byte, 'R' reads status, anything else is NAKed.
  always_comb begin
    p_state_nx = p_state;
    led_nx     = pio_led_export;
    rep_load   = 1'b0;
    rep_byte   = 8'h00;
    if (rx_valid) begin
      if (p_state == P_CMD) begin
        case (rx_sh)
          8'h4C: p_state_nx = P_ARG;
          8'h52: begin
            rep_load = 1'b1;
            rep_byte = status_byte;
          end
          default: begin
            rep_load = 1'b1;
            rep_byte = 8'h15;
          end
        endcase
      end else begin
        led_nx     = rx_sh[LED_W-1:0];
        rep_load   = 1'b1;
        rep_byte   = 8'h06;
        p_state_nx = P_CMD;
      end
    end else if (rx_err) begin
      p_state_nx = P_CMD;
    end
  end

  // ---------------- TX arbitration ----------------
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  tx_state_t        tx_state, tx_state_nx;
  logic [CW-1:0]    tx_cnt, tx_cnt_nx;
  logic [3:0]       tx_bit, tx_bit_nx;
  logic [8:0]       tx_sh, tx_sh_nx;
  logic             tx_out_nx;
  logic             tx_free, grab_slot, grab_evt, rep_drop;
  logic             slot_vld;
  logic [7:0]       slot_byte, evt_byte;
  logic [BTN_W-1:0] evt_flag, evt_clr;

  // The last stop-bit cycle also counts as free, so frames can run back-to-back.
  // The slot wins over events, and among events the lowest index wins.
  always_comb begin
    tx_free   = (tx_state == TX_IDLE) ||
                ((tx_state == TX_BUSY) && (tx_cnt == '0) && (tx_bit == 4'd9));
    grab_slot = tx_free && slot_vld;
    grab_evt  = tx_free && !slot_vld && (|evt_flag);
    evt_clr   = '0;
    evt_byte  = 8'h80;
    for (int i = BTN_W - 1; i >= 0; i--) begin
      if (evt_flag[i]) begin
        evt_clr    = '0;
        evt_clr[i] = grab_evt;
        evt_byte   = 8'h80 | 8'(i);
      end
    end
    rep_drop = rep_load && slot_vld && !grab_slot;
  end

  // ---------------- transmitter ----------------
  // Transmitter next state: a grab drives the start bit, then 8 data bits and a stop bit are shifted out.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_sh_nx    = tx_sh;
    tx_out_nx   = uart_txd;
    if (grab_slot || grab_evt) begin
      tx_state_nx = TX_BUSY;
      tx_cnt_nx   = BIT_LAST;
      tx_bit_nx   = 4'd0;
      tx_sh_nx    = {1'b1, (grab_slot ? slot_byte : evt_byte)};
      tx_out_nx   = 1'b0;
    end else if (tx_state == TX_BUSY) begin
      if (tx_cnt != '0) tx_cnt_nx = tx_cnt - CW'(1);
      else if (tx_bit == 4'd9) begin
        tx_state_nx = TX_IDLE;
        tx_out_nx   = 1'b1;
      end else begin
        tx_cnt_nx = BIT_LAST;
        tx_bit_nx = tx_bit + 4'd1;
        tx_out_nx = tx_sh[0];
        tx_sh_nx  = {1'b1, tx_sh[8:1]};
      end
    end else begin
      tx_out_nx = 1'b1;
    end
  end

  // Registers for the transmitter, parser, reply slot, event flags and the error counter.
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      tx_state       <= TX_IDLE;
      tx_cnt         <= '0;
      tx_bit         <= '0;
      tx_sh          <= '1;
      uart_txd       <= 1'b1;
      p_state        <= P_CMD;
      pio_led_export <= '0;
      slot_vld       <= 1'b0;
      slot_byte      <= '0;
      evt_flag       <= '0;
      frame_err_cnt  <= '0;
    end else begin
      tx_state       <= tx_state_nx;
      tx_cnt         <= tx_cnt_nx;
      tx_bit         <= tx_bit_nx;
      tx_sh          <= tx_sh_nx;
      uart_txd       <= tx_out_nx;
      p_state        <= p_state_nx;
      pio_led_export <= led_nx;
      // A new reply is accepted when the slot is empty or being emptied this cycle.
      if (rep_load && (!slot_vld || grab_slot)) begin
        slot_vld  <= 1'b1;
        slot_byte <= rep_byte;
      end else if (grab_slot) begin
        slot_vld <= 1'b0;
      end
      // A set takes precedence over a clear in the same cycle.
      evt_flag <= btn_fall | (evt_flag & ~evt_clr);
      if ((rx_err || rep_drop) && (frame_err_cnt != 8'hFF))
        frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_pio_bridge.sv
// Directed bench for uart_pio_bridge with BAUD_DIV=16 and DEBOUNCE_CYC=8.
module tb_uart_pio_bridge;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       reset_reset;
  logic       pll_locked;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] pio_led_export;
  logic [2:0] pio_switch_export;
  logic [1:0] pio_button_export;
  logic [7:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;

  logic       got;
  logic [8:0] fr;
  int         t0;

  uart_pio_bridge #(
    .BAUD_DIV(BD), .LED_W(8), .SW_W(3), .BTN_W(2), .DEBOUNCE_CYC(8)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .pll_locked(pll_locked),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .pio_led_export(pio_led_export),
    .pio_switch_export(pio_switch_export),
    .pio_button_export(pio_button_export),
    .frame_err_cnt(frame_err_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame. The caller sits on a negedge; the task ends on one with the line idle.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    tick(BD);
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      tick(BD);
    end
    uart_rxd = stop;
    tick(BD);
    uart_rxd = 1'b1;
  endtask

  // Waits up to budget negedges for a start bit, then samples mid-bit.
  // frame = {stop, data}; t0 = index of the first negedge that saw the line low.
  task automatic mon_tx(input int budget, output logic g, output logic [8:0] frame, output int t);
    g = 1'b0;
    frame = 9'h000;
    t = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        g = 1'b1;
        t = c;
        break;
      end
    end
    if (g) begin
      tick(7);
      for (int k = 0; k < 9; k++) begin
        tick(BD);
        frame[k] = uart_txd;
      end
    end
  endtask

  task automatic xfer(input logic [7:0] b, input logic stop, output logic g,
                      output logic [8:0] frame, output int t);
    fork
      send_byte(b, stop);
      mon_tx(200, g, frame, t);
    join
  endtask

  initial begin
    // reset
    reset_reset = 1'b1;
    pll_locked = 1'b1;
    uart_rxd = 1'b1;
    pio_switch_export = 3'b000;
    pio_button_export = 2'b11;
    tick(5);
    reset_reset = 1'b0;
    tick(2);
    check("reset_txd", 32'(uart_txd), 32'h1);
    check("reset_led", 32'(pio_led_export), 32'h00);
    check("reset_err", 32'(frame_err_cnt), 32'h00);

    // PLL unlocked: a full frame must not produce any TX activity
    pll_locked = 1'b0;
    xfer(8'h52, 1'b1, got, fr, t0);
    check("pll_low_txd_idle", 32'(got), 32'h0);
    check("pll_low_err", 32'(frame_err_cnt), 32'h00);
    pll_locked = 1'b1;
    tick(5);

    // LED write
    xfer(8'h4C, 1'b1, got, fr, t0);
    check("led_cmd_no_reply", 32'(got), 32'h0);
    xfer(8'hA5, 1'b1, got, fr, t0);
    check("led_ack", 32'(fr), 32'h106);
    check("led_ack_latency", 32'((t0 >= 144) && (t0 <= 157)), 32'h1);
    check("led_value", 32'(pio_led_export), 32'hA5);
    tick(20);

    // Status read with button0 held: its press event goes out first
    pio_switch_export = 3'b101;
    pio_button_export = 2'b10;
    mon_tx(60, got, fr, t0);
    check("btn0_event", 32'(fr), 32'h180);
    tick(20);
    xfer(8'h52, 1'b1, got, fr, t0);
    check("status_read", 32'(fr), 32'h10D);
    tick(20);
    pio_button_export = 2'b11;
    mon_tx(40, got, fr, t0);
    check("release_no_event", 32'(got), 32'h0);

    // NAK
    xfer(8'h33, 1'b1, got, fr, t0);
    check("nak", 32'(fr), 32'h115);
    tick(20);

    // framing error
    xfer(8'h33, 1'b0, got, fr, t0);
    check("ferr_no_reply", 32'(got), 32'h0);
    check("ferr_count1", 32'(frame_err_cnt), 32'h01);
    tick(4);

    // framing error in the argument slot returns the parser to the command state
    xfer(8'h4C, 1'b1, got, fr, t0);
    check("arg_cmd_no_reply", 32'(got), 32'h0);
    xfer(8'h99, 1'b0, got, fr, t0);
    check("arg_ferr_no_reply", 32'(got), 32'h0);
    check("arg_ferr_led", 32'(pio_led_export), 32'hA5);
    check("arg_ferr_count", 32'(frame_err_cnt), 32'h02);
    tick(4);
    xfer(8'h52, 1'b1, got, fr, t0);
    check("after_arg_ferr_status", 32'(fr), 32'h105);
    check("after_arg_ferr_led", 32'(pio_led_export), 32'hA5);
    tick(20);

    // both buttons pressed together: 0x80 then 0x81 back-to-back
    pio_button_export = 2'b00;
    mon_tx(60, got, fr, t0);
    check("dual_evt_first", 32'(fr), 32'h180);
    mon_tx(40, got, fr, t0);
    check("dual_evt_second", 32'(fr), 32'h181);
    check("dual_evt_gap", 32'(t0), 32'd8);
    tick(20);
    pio_button_export = 2'b11;
    tick(20);

    // 5-cycle bounce on button0 must not produce an event
    pio_button_export = 2'b10;
    tick(5);
    pio_button_export = 2'b11;
    mon_tx(40, got, fr, t0);
    check("bounce_no_event", 32'(got), 32'h0);

    // The button1 event occupies TX while button0's flag and the status reply both wait.
    // The reply goes out before the pending button0 event.
    fork
      send_byte(8'h52, 1'b1);
      begin
        tick(30);
        pio_button_export = 2'b01;
        tick(30);
        pio_button_export = 2'b00;
      end
      begin
        logic [8:0] f1, f2, f3;
        logic g1, g2, g3;
        int ta, tb, tc;
        mon_tx(200, g1, f1, ta);
        mon_tx(200, g2, f2, tb);
        mon_tx(200, g3, f3, tc);
        check("prio_first_evt1", 32'(f1), 32'h181);
        check("prio_reply_second", 32'(f2), 32'h11D);
        check("prio_evt0_third", 32'(f3), 32'h180);
      end
    join
    tick(20);
    pio_button_export = 2'b11;
    tick(20);

    // saturation of the error counter after 300 more framing errors
    for (int n = 0; n < 300; n++) begin
      send_byte(8'h55, 1'b0);
      tick(4);
      if (n == 252) check("err_cnt_255_reached", 32'(frame_err_cnt), 32'hFF);
    end
    check("err_cnt_saturated", 32'(frame_err_cnt), 32'hFF);
    tick(4);
    xfer(8'h33, 1'b1, got, fr, t0);
    check("post_sat_nak", 32'(fr), 32'h115);
    check("post_sat_err", 32'(frame_err_cnt), 32'hFF);
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
